// File: rtl/conv1d_filter_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_filter_sched
// Brief    : Sequencer for the conv1d filter loop. Tracks window position and
//            filter index while the recycler replays a frame once per filter.
//            It issues weight/bias reads so that their data lands alongside
//            the registered window tag, and it flags framing errors.
// Revision : 1.0 - initial release
// ============================================================================
module conv1d_filter_sched #(
  parameter int FRAME_LEN   = 50,
  parameter int NUM_FILTERS = 8,
  parameter int POS_BW      = $clog2(FRAME_LEN),
  parameter int FILT_BW     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               win_valid_i,
  input  logic               win_last_i,
  output logic               win_ready_o,
  output logic               wmem_rd_en_o,
  output logic [FILT_BW-1:0] wmem_addr_o,
  output logic [FILT_BW-1:0] bias_addr_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [FILT_BW-1:0] filter_idx_o,
  output logic [POS_BW-1:0]  pos_o,
  output logic               first_o,
  output logic               pass_last_o,
  output logic               frame_last_o,
  output logic               frame_done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [POS_BW-1:0]  c_pos_last  = POS_BW'(FRAME_LEN - 1);
  localparam logic [FILT_BW-1:0] c_filt_last = FILT_BW'(NUM_FILTERS - 1);

  state_t              r_state;
  logic [POS_BW-1:0]   r_pos;
  logic [FILT_BW-1:0]  r_filt;

  logic w_out_free;
  logic w_accept;
  logic w_pos_last;
  logic w_filt_last;

  // The single output register can take a new tag when empty or being drained.
  assign w_out_free  = ~valid_o | ready_i;
  assign w_pos_last  = (r_pos == c_pos_last);
  assign w_filt_last = (r_filt == c_filt_last);
  assign w_accept    = win_valid_i & win_ready_o;

  // Read strobe and addresses issue in the accept cycle so data meets the tag.
  assign wmem_rd_en_o = w_accept;
  assign wmem_addr_o  = r_filt;
  assign bias_addr_o  = r_filt;

  // Window handshake: new frames start only when enabled; FLUSH blocks input.
  always_comb begin
    win_ready_o = 1'b0;
    unique case (r_state)
      S_IDLE:  win_ready_o = enable_i & w_out_free;
      S_RUN:   win_ready_o = w_out_free;
      S_FLUSH: win_ready_o = 1'b0;
      default: win_ready_o = 1'b0;
    endcase
  end

  // Frame FSM, position/filter counters, output tag register and error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_pos        <= '0;
      r_filt       <= '0;
      valid_o      <= 1'b0;
      filter_idx_o <= '0;
      pos_o        <= '0;
      first_o      <= 1'b0;
      pass_last_o  <= 1'b0;
      frame_last_o <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;

      if (w_accept) begin
        valid_o      <= 1'b1;
        filter_idx_o <= r_filt;
        pos_o        <= r_pos;
        first_o      <= (r_pos == '0);
        pass_last_o  <= w_pos_last;
        frame_last_o <= w_pos_last & w_filt_last;
        // Counters remain authoritative; a mismatching last flag only sets err.
        if (win_last_i != w_pos_last) begin
          err_o <= 1'b1;
        end
        if (w_pos_last) begin
          r_pos  <= '0;
          r_filt <= w_filt_last ? '0 : r_filt + FILT_BW'(1);
        end else begin
          r_pos <= r_pos + POS_BW'(1);
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept & w_pos_last & w_filt_last) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Only the frame_last tag can be pending here; its drain ends the frame.
          if (valid_o & ready_i & frame_last_o) begin
            r_state      <= S_IDLE;
            frame_done_o <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
